// File: rtl/prog_mem_loader.sv
// Program/data memory with a boot sequencer: sweeps the array to zero, loads an image from a
// valid/ready stream, then releases the CPU and serves an instruction port and a data port.
module prog_mem_loader #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DEPTH          = 256,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_rst,
    output logic              busy,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] instr_out,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] write_data_b,
    output logic [DATA_W-1:0] data_out_b
);

    localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {StClear, StLoad, StRun} state_e;

    state_e            r_state, w_state_d;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  r_cptr;
    logic [ADDR_W:0]   r_lptr;
    logic              r_cpu_rst, r_busy, r_load_err;

    logic              w_accept, w_lfull, w_a_ok, w_b_ok, w_mem_we;
    logic [IDX_W-1:0]  w_mem_idx;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_lfull  = (r_lptr == LP_DEPTH);
    assign w_accept = load_valid & load_ready;
    assign w_a_ok   = ({1'b0, addr_a} < LP_DEPTH);
    assign w_b_ok   = ({1'b0, addr_b} < LP_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? StClear : StLoad;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StClear: if (r_cptr == LP_LAST) w_state_d = StLoad;
            StLoad:  if (w_accept && load_last) w_state_d = StRun;
            StRun:   w_state_d = StRun;
            default: w_state_d = StClear;
        endcase
    end

    // One shared write port: the sweep, the load stream and port B never overlap in time.
    always_comb begin
        load_ready  = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_idx   = '0;
        w_mem_wdata = '0;
        unique case (r_state)
            StClear: begin
                w_mem_we  = 1'b1;
                w_mem_idx = r_cptr;
            end
            StLoad: begin
                load_ready  = 1'b1;
                w_mem_we    = load_valid & ~w_lfull;
                w_mem_idx   = r_lptr[IDX_W-1:0];
                w_mem_wdata = load_data;
            end
            StRun: begin
                w_mem_we    = we_b & w_b_ok;
                w_mem_idx   = addr_b[IDX_W-1:0];
                w_mem_wdata = write_data_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cptr     <= '0;
            r_lptr     <= '0;
            r_load_err <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_busy     <= 1'b1;
        end else begin
            r_cpu_rst <= (w_state_d != StRun);
            r_busy    <= (w_state_d != StRun);
            if (r_state == StClear) begin
                r_cptr <= r_cptr + IDX_W'(1);
            end
            if (w_accept) begin
                if (w_lfull) begin
                    r_load_err <= 1'b1;
                end else begin
                    r_lptr <= r_lptr + (ADDR_W + 1)'(1);
                end
            end
        end
    end

    // rst also holds the CPU in reset directly so it never sees a stale RUN for one cycle.
    assign cpu_rst    = r_cpu_rst | rst;
    assign busy       = r_busy;
    assign load_err   = r_load_err;
    assign load_count = r_lptr;

    assign instr_out  = (r_state == StRun && w_a_ok) ? r_mem[addr_a[IDX_W-1:0]] : '0;
    assign data_out_b = (r_state == StRun && w_b_ok) ? r_mem[addr_b[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized bench for prog_mem_loader: a 256-word instance with clear sweep and a 16-word
// instance without it, both compared against a simple array model of memory contents.
module tb_prog_mem_loader;

    localparam int DEP  = 256;
    localparam int SDEP = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, load_valid, load_last, we_b;
    logic [7:0] load_data, addr_a, addr_b, write_data_b;
    logic       load_ready, cpu_rst, busy, load_err;
    logic [8:0] load_count;
    logic [7:0] instr_out, data_out_b;

    logic       s_rst, s_load_valid, s_load_last, s_we_b;
    logic [7:0] s_load_data, s_addr_a, s_addr_b, s_write_data_b;
    logic       s_load_ready, s_cpu_rst, s_busy, s_load_err;
    logic [8:0] s_load_count;
    logic [7:0] s_instr_out, s_data_out_b;

    prog_mem_loader #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEP), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .cpu_rst(cpu_rst), .busy(busy),
        .load_err(load_err), .load_count(load_count), .addr_a(addr_a), .instr_out(instr_out),
        .we_b(we_b), .addr_b(addr_b), .write_data_b(write_data_b), .data_out_b(data_out_b)
    );

    prog_mem_loader #(.DATA_W(8), .ADDR_W(8), .DEPTH(SDEP), .CLEAR_ON_RESET(1'b0)) u_dut16 (
        .clk(clk), .rst(s_rst), .load_valid(s_load_valid), .load_data(s_load_data),
        .load_last(s_load_last), .load_ready(s_load_ready), .cpu_rst(s_cpu_rst),
        .busy(s_busy), .load_err(s_load_err), .load_count(s_load_count), .addr_a(s_addr_a),
        .instr_out(s_instr_out), .we_b(s_we_b), .addr_b(s_addr_b),
        .write_data_b(s_write_data_b), .data_out_b(s_data_out_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain array of what each word should hold, plus load bookkeeping.
    logic [7:0] m_mem [DEP];
    int         m_count;
    bit         m_err;
    logic [7:0] sm_mem [SDEP];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic main_reset();
        @(negedge clk);
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; we_b = 1'b0;
        #1 check_eq("cpu_rst_during_rst", cpu_rst, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_load_count", load_count, 0);
        check_eq("rst_load_err", load_err, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_cpu_rst", cpu_rst, 1);
        for (int i = 0; i < DEP; i++) m_mem[i] = 8'h00;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic wait_clear();
        int n = 0;
        int bad = 0;
        while (load_ready !== 1'b1 && n < 1000) begin
            addr_a = 8'($urandom);
            addr_b = 8'($urandom);
            #1;
            if (instr_out !== 8'h00 || data_out_b !== 8'h00 || busy !== 1'b1 ||
                cpu_rst !== 1'b1) bad++;
            @(negedge clk);
            n++;
        end
        check_eq("clear_cycles", n, DEP);
        check_eq("clear_outputs_bad", bad, 0);
        check_eq("load_busy", busy, 1);
    endtask

    task automatic load_image(input logic [7:0] words[$], input bit gaps);
        int bad_ready = 0;
        int last_i = words.size() - 1;
        for (int i = 0; i <= last_i; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    load_valid   = 1'b0;
                    load_last    = 1'($urandom_range(0, 1));
                    load_data    = 8'($urandom);
                    we_b         = 1'b1;
                    addr_b       = 8'($urandom);
                    write_data_b = 8'($urandom);
                    @(negedge clk);
                end
            end
            we_b       = 1'b0;
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = (i == last_i);
            #1;
            if (load_ready !== 1'b1) bad_ready++;
            if (i == last_i) check_eq("cpu_rst_before_last", cpu_rst, 1);
            @(posedge clk);
            if (m_count < DEP) begin
                m_mem[m_count] = words[i];
                m_count++;
            end else begin
                m_err = 1'b1;
            end
            #1;
            if (i == last_i) check_eq("cpu_rst_fall_on_accept", cpu_rst, 0);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check_eq("load_ready_in_load_bad", bad_ready, 0);
        check_eq("run_cpu_rst", cpu_rst, 0);
        check_eq("run_busy", busy, 0);
        check_eq("run_load_ready", load_ready, 0);
        check_eq("run_load_count", load_count, m_count);
        check_eq("run_load_err", load_err, m_err);
    endtask

    task automatic verify_all(input string tag);
        int bad = 0;
        for (int i = 0; i < DEP; i++) begin
            addr_a = 8'(i);
            addr_b = 8'(DEP - 1 - i);
            #1;
            if (instr_out !== m_mem[i] || data_out_b !== m_mem[DEP - 1 - i]) bad++;
        end
        check_eq(tag, bad, 0);
        @(negedge clk);
    endtask

    task automatic write_b(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        we_b = 1'b1; addr_b = a; write_data_b = d; addr_a = a;
        #1;
        check_eq("wr_old_b", data_out_b, m_mem[a]);
        check_eq("wr_old_a", instr_out, m_mem[a]);
        @(posedge clk);
        m_mem[a] = d;
        @(negedge clk);
        we_b = 1'b0;
        #1;
        check_eq("wr_new_b", data_out_b, d);
        check_eq("wr_new_a", instr_out, d);
    endtask

    task automatic verify_small(input string tag);
        int bad = 0;
        for (int i = 0; i < SDEP; i++) begin
            s_addr_a = 8'(i);
            s_addr_b = 8'(SDEP - 1 - i);
            #1;
            if (s_instr_out !== sm_mem[i] || s_data_out_b !== sm_mem[SDEP - 1 - i]) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    logic [7:0] img12 [$] = '{8'h00, 8'h21, 8'h31, 8'h41, 8'h51, 8'h61, 8'h65, 8'h81,
                              8'h85, 8'h89, 8'h8D, 8'h00};
    logic [7:0] words [$];
    logic [7:0] a_w, d_w;

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        addr_a = '0; addr_b = '0; we_b = 1'b0; write_data_b = '0;
        s_rst = 1'b1; s_load_valid = 1'b0; s_load_last = 1'b0; s_load_data = '0;
        s_addr_a = '0; s_addr_b = '0; s_we_b = 1'b0; s_write_data_b = '0;

        // Fill the whole array with a random image so the next sweep has something to clear.
        main_reset();
        wait_clear();
        words.delete();
        for (int i = 0; i < DEP; i++) words.push_back(8'($urandom_range(1, 255)));
        load_image(words, 1'b0);
        verify_all("prefill_contents");

        main_reset();
        wait_clear();
        load_image(img12, 1'b0);
        check_eq("img12_count", load_count, 12);
        addr_a = 8'd1;  #1 check_eq("img12_a1", instr_out, 8'h21);
        addr_a = 8'd10; #1 check_eq("img12_a10", instr_out, 8'h8D);
        addr_a = 8'd20; #1 check_eq("img12_a20", instr_out, 8'h00);
        verify_all("img12_contents");

        write_b(8'h40, 8'h5C);
        for (int i = 0; i < 6; i++) begin
            a_w = 8'($urandom);
            d_w = 8'($urandom);
            write_b(a_w, d_w);
        end
        verify_all("after_port_b_writes");

        // Same image with gaps, stray load_last and port-B writes while loading.
        main_reset();
        wait_clear();
        load_image(img12, 1'b1);
        check_eq("gap_count", load_count, 12);
        verify_all("gap_contents");

        // Abort a load after five words.
        main_reset();
        wait_clear();
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom);
            load_last  = 1'b0;
            @(negedge clk);
        end
        check_eq("partial_count", load_count, 5);
        check_eq("partial_cpu_rst", cpu_rst, 1);
        main_reset();
        wait_clear();
        words.delete();
        for (int i = 0; i < 3; i++) words.push_back(8'($urandom));
        load_image(words, 1'b1);
        check_eq("reload_err", load_err, 0);
        verify_all("reload_contents");

        // Small instance: no sweep, overflowing image, out-of-range port accesses.
        @(negedge clk);
        s_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_rst = 1'b0;
        check_eq("s_ready_after_rst", s_load_ready, 1);
        check_eq("s_busy_after_rst", s_busy, 1);
        check_eq("s_cpu_rst_after_rst", s_cpu_rst, 1);
        check_eq("s_count_after_rst", s_load_count, 0);
        for (int i = 0; i < 18; i++) begin
            s_load_valid = 1'b1;
            s_load_data  = 8'($urandom);
            s_load_last  = (i == 17);
            if (i < SDEP) sm_mem[i] = s_load_data;
            @(negedge clk);
        end
        s_load_valid = 1'b0;
        s_load_last  = 1'b0;
        check_eq("s_load_err", s_load_err, 1);
        check_eq("s_load_count", s_load_count, SDEP);
        check_eq("s_cpu_rst_run", s_cpu_rst, 0);
        s_addr_a = 8'd15; #1 check_eq("s_word16_at_15", s_instr_out, sm_mem[15]);
        verify_small("s_contents");
        s_addr_a = 8'd20; s_addr_b = 8'd20;
        #1;
        check_eq("s_oor_read_a", s_instr_out, 0);
        check_eq("s_oor_read_b", s_data_out_b, 0);
        @(negedge clk);
        s_we_b = 1'b1; s_addr_b = 8'd20; s_write_data_b = ~sm_mem[4];
        @(negedge clk);
        s_we_b = 1'b0;
        #1 check_eq("s_oor_after_write", s_data_out_b, 0);
        verify_small("s_contents_after_oor_write");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
